systolic_mm_top: RTL and testbench
==================================

Name: systolic_mm_top

Overview:
- Top-level matrix-multiply accelerator: O[MxN] = A[MxK] x W[KxN], computed on an 8x8 systolic PE array.
- Contains a special-purpose (SP) register file, A and W input memories, an O output memory and a controller.
- Host writes SP/A/W through three write ports and reads results through an asynchronous O read port.
- Supports weight-stationary (mode 0) and output-stationary (mode 1) dataflows with identical numeric results.

Parameters:
- DIM, 8, PE array edge and max value of M, K, N.
- DATA_W, 8, signed operand width (low byte of each A/W word).
- ACC_W, 32, accumulator and O word width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- sp_addr  input  32  SP byte address; word index = sp_addr[4:2].
- sp_data_in  input  32  SP write data.
- sp_web  input  4  SP byte write enables (bit i writes byte i).
- a_addr  input  32  A memory byte address; word index = a_addr[7:2].
- a_data_in  input  32  A write data.
- a_web  input  4  A byte write enables.
- w_addr  input  32  W memory byte address; word index = w_addr[7:2].
- w_data_in  input  32  W write data.
- w_web  input  4  W byte write enables.
- O_addr  input  32  O memory byte address; word index = O_addr[7:2].
- O_data  output  32  O word at O_addr; combinational (asynchronous) read.

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- SP map, byte-enabled synchronous writes:
  - word0 = start (bit0),
  - word1 = mode (bit0; 0 = WS, 1 = OS),
  - word2 = M, word3 = K, word4 = N (low 4 bits).
  - Words 5-7 ignored. Address bits above the index are ignored.
- A/W memories:
  - 64 x 32-bit each, synchronous byte-enabled host writes.
  - Element = signed [7:0] of a word; upper bits ignored.
  - Row-major packed by actual dims: A[m][k] at word m*K+k; W[k][n] at word k*N+n.
- O memory:
  - 64 x 32-bit; O[m][n] at word m*N+n, stored as a signed 32-bit sum (sign-extended).
  - Only the controller writes O. Words >= M*N are untouched.
- Reset: clears all SP registers, controller to IDLE, all PE registers/accumulators to 0. A/W/O contents are not cleared.
- Controller FSM: IDLE -> LOAD -> COMPUTE -> DRAIN -> WRITE -> DONE.
  - IDLE -> LOAD when start=1. M, K, N, mode are captured at that edge; later SP writes do not affect the running job.
  - If any captured dim is 0 or >8: go directly to DONE with no O writes.
  - LOAD: read A/W one word per cycle into array skew buffers.
    - WS: W[k][n] preloaded into PE(k,n).
    - OS: operands staged for streaming.
  - COMPUTE: skewed streaming.
    - WS: A rows enter the left edge, partial sums flow down.
    - OS: A flows right, W flows down, PE(m,n) accumulates.
    - Run until all K products are reduced.
  - DRAIN: flush pipeline.
  - WRITE: one O word per cycle, m-major.
  - DONE: hold; results stable. Returns to IDLE only when start is written 0.
  - Start held at 1 must not retrigger.
- PE arithmetic: 8x8 signed multiply into a 16-bit product; ACC_W accumulation; no saturation. Inactive PEs (m>=M, k>=K, n>=N) contribute 0.
- Latency: start sample to DONE <= 250 cycles for M=K=N=8.
- O read during a job returns the current memory contents (old or new word).
- Host writes to A/W during a job: undefined results; no lock-up.
- Reset mid-job: aborts to IDLE next edge; partial O writes remain.
- Simultaneous host write and controller read of the same A/W word: the controller sees the old data.

Test Plan:
- TEST1: mode=1, M=K=N=8, all A=-2, W=2, start=1, wait 300 cycles -> O words 0..63 = -32 (0xFFFFFFE0); repeat with mode=0 -> same.
- TEST2: mode 0 and 1, M=7, K=8, N=3, A=-2, W=2 -> O words 0..20 = -32; word 21 unchanged.
- TEST3: mode 0 and 1, M=3, K=4, N=2, A[m][k]=m+k, W[k][n]=k-n -> O[m][n] = sum_k (m+k)(k-n), e.g. O[0][0]=14, O[2][1]=12 at word 5.
- TEST4: mode 0 and 1, M=6, K=7, N=3, A=-128, W=-128 -> O words 0..17 = 114688; also A=127, W=-128 -> -113792.
- Control: start held 1 after DONE -> no rewrite (O stable); write start=0 then 1 with new dims -> new result; reset asserted mid-COMPUTE -> FSM IDLE, next start completes correctly.
- Dim guard: K=0 or N=9 with start=1 -> DONE with O unchanged.

Source files
------------

// File: rtl/systolic_mm_top.sv
// Matrix-multiply accelerator: O = A x W on a DIM x DIM systolic PE grid,
// weight-stationary (mode 0) or output-stationary (mode 1) dataflow.

module systolic_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     os_mode,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] w_pre,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] w_in,
  input  logic signed [ACC_W-1:0]  psum_in,
  output logic signed [DATA_W-1:0] a_q,
  output logic signed [DATA_W-1:0] w_q,
  output logic signed [ACC_W-1:0]  acc_q
);
  logic signed [DATA_W-1:0]   a_d, w_d;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [2*DATA_W-1:0] prod;

  // OS: w streams through w_q and acc is local. WS: w_q holds the weight and
  // acc_q is the partial sum handed down to the next row.
  always_comb begin
    w_d   = os_mode ? w_in : w_q;
    prod  = a_in * w_d;
    a_d   = a_in;
    acc_d = (os_mode ? acc_q : psum_in) + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    if (clr) begin
      a_d   = '0;
      w_d   = os_mode ? '0 : w_pre;
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      w_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      w_q   <= w_d;
      acc_q <= acc_d;
    end
  end
endmodule

module systolic_mm_top #(
  parameter int DIM    = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] sp_addr,
  input  logic [31:0] sp_data_in,
  input  logic [3:0]  sp_web,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_data_in,
  input  logic [3:0]  a_web,
  input  logic [31:0] w_addr,
  input  logic [31:0] w_data_in,
  input  logic [3:0]  w_web,
  input  logic [31:0] O_addr,
  output logic [31:0] O_data
);
  localparam int IW    = $clog2(DIM);
  localparam int DEPTH = DIM * DIM;
  localparam int AW    = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, WRITE, DONE} state_t;

  logic [31:0] a_mem [DEPTH];
  logic [31:0] w_mem [DEPTH];
  logic [31:0] o_mem [DEPTH];

  logic       sp_start_q, sp_start_d, sp_mode_q, sp_mode_d;
  logic [3:0] sp_m_q, sp_m_d, sp_k_q, sp_k_d, sp_n_q, sp_n_d;

  always_comb begin
    sp_start_d = sp_start_q;
    sp_mode_d  = sp_mode_q;
    sp_m_d     = sp_m_q;
    sp_k_d     = sp_k_q;
    sp_n_d     = sp_n_q;
    if (sp_web[0]) begin
      case (sp_addr[4:2])
        3'd0:    sp_start_d = sp_data_in[0];
        3'd1:    sp_mode_d  = sp_data_in[0];
        3'd2:    sp_m_d     = sp_data_in[3:0];
        3'd3:    sp_k_d     = sp_data_in[3:0];
        3'd4:    sp_n_d     = sp_data_in[3:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_start_q <= 1'b0;
      sp_mode_q  <= 1'b0;
      sp_m_q     <= '0;
      sp_k_q     <= '0;
      sp_n_q     <= '0;
    end else begin
      sp_start_q <= sp_start_d;
      sp_mode_q  <= sp_mode_d;
      sp_m_q     <= sp_m_d;
      sp_k_q     <= sp_k_d;
      sp_n_q     <= sp_n_d;
    end
  end

  state_t                   state_q;
  logic                     os_q, o_we_q;
  logic [3:0]               dm_q, dk_q, dn_q;
  logic [7:0]               cnt_q, mk, kn, mn, nload;
  logic [IW-1:0]            row_q, col_q, wk_q, wn_q;
  logic [4:0]               t_q;
  logic [AW-1:0]            o_idx_q;
  logic [31:0]              o_wdata_q;
  logic signed [DATA_W-1:0] a_buf [DIM][DIM];
  logic signed [DATA_W-1:0] w_buf [DIM][DIM];
  logic signed [ACC_W-1:0]  res   [DIM][DIM];
  logic signed [DATA_W-1:0] a_h   [DIM][DIM];
  logic signed [DATA_W-1:0] w_v   [DIM][DIM];
  logic signed [ACC_W-1:0]  acc   [DIM][DIM];
  logic signed [DATA_W-1:0] a_edge [DIM];
  logic signed [DATA_W-1:0] w_edge [DIM];
  logic                     dims_bad, pe_clr;
  logic [DIM-1:0]           unused_edge;
  logic                     unused_ports;

  assign mk       = 8'(dm_q) * 8'(dk_q);
  assign kn       = 8'(dk_q) * 8'(dn_q);
  assign mn       = 8'(dm_q) * 8'(dn_q);
  assign nload    = (mk > kn) ? mk : kn;
  assign dims_bad = (sp_m_q == 4'd0) || (sp_m_q > 4'(DIM)) || (sp_k_q == 4'd0) ||
                    (sp_k_q > 4'(DIM)) || (sp_n_q == 4'd0) || (sp_n_q > 4'(DIM));
  // LOAD clears PE state every cycle; its final cycle latches the complete WS weights.
  assign pe_clr   = (state_q == LOAD);
  assign O_data   = o_mem[O_addr[AW+1:2]];
  assign unused_ports = ^{sp_addr[31:5], sp_addr[1:0], sp_data_in[31:4], sp_web[3:1],
                          a_addr[31:8], a_addr[1:0], w_addr[31:8], w_addr[1:0],
                          O_addr[31:8], O_addr[1:0]};

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (a_web[b]) a_mem[a_addr[AW+1:2]][8*b +: 8] <= a_data_in[8*b +: 8];
      if (w_web[b]) w_mem[w_addr[AW+1:2]][8*b +: 8] <= w_data_in[8*b +: 8];
    end
    if (o_we_q) o_mem[o_idx_q] <= o_wdata_q;
  end

  // Edge feed: lane g sees element index t-g, so operand (m,k,n) meets at t = m+k+n.
  for (genvar g = 0; g < DIM; g++) begin : g_edge
    logic [4:0] d;
    logic       in_win;
    assign d           = t_q - 5'(g);
    assign in_win      = (state_q == COMPUTE) && (t_q >= 5'(g)) && (d < 5'(DIM));
    assign a_edge[g]   = !in_win ? '0 : os_q ? a_buf[g][d[IW-1:0]] : a_buf[d[IW-1:0]][g];
    assign w_edge[g]   = (in_win && os_q) ? w_buf[d[IW-1:0]][g] : '0;
    assign unused_edge[g] = ^{a_h[g][DIM-1], w_v[DIM-1][g]};
  end

  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      logic signed [DATA_W-1:0] ain, win;
      logic signed [ACC_W-1:0]  pin;
      if (c == 0) begin : g_l
        assign ain = a_edge[r];
      end else begin : g_li
        assign ain = a_h[r][c-1];
      end
      if (r == 0) begin : g_t
        assign win = w_edge[c];
        assign pin = '0;
      end else begin : g_ti
        assign win = w_v[r-1][c];
        assign pin = acc[r-1][c];
      end
      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk(clk), .reset(reset), .os_mode(os_q), .clr(pe_clr), .w_pre(w_buf[r][c]),
        .a_in(ain), .w_in(win), .psum_in(pin),
        .a_q(a_h[r][c]), .w_q(w_v[r][c]), .acc_q(acc[r][c])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      os_q      <= 1'b0;
      dm_q      <= '0;
      dk_q      <= '0;
      dn_q      <= '0;
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wk_q      <= '0;
      wn_q      <= '0;
      t_q       <= '0;
      o_we_q    <= 1'b0;
      o_idx_q   <= '0;
      o_wdata_q <= '0;
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) begin
          a_buf[r][c] <= '0;
          w_buf[r][c] <= '0;
          res[r][c]   <= '0;
        end
    end else begin
      o_we_q <= 1'b0;
      // WS: column c's bottom PE emits row m's sum at t = m + c + DIM.
      if (!os_q && (state_q == COMPUTE || state_q == DRAIN))
        for (int c = 0; c < DIM; c++)
          if (t_q >= 5'(c + DIM) && t_q < 5'(c + 2*DIM))
            res[IW'(t_q - 5'(c + DIM))][c] <= acc[DIM-1][c];
      case (state_q)
        IDLE: if (sp_start_q) begin
          os_q  <= sp_mode_q;
          dm_q  <= sp_m_q;
          dk_q  <= sp_k_q;
          dn_q  <= sp_n_q;
          cnt_q <= '0;
          row_q <= '0;
          col_q <= '0;
          wk_q  <= '0;
          wn_q  <= '0;
          t_q   <= '0;
          for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
              a_buf[r][c] <= '0;
              w_buf[r][c] <= '0;
            end
          state_q <= dims_bad ? DONE : LOAD;
        end
        LOAD: begin
          if (cnt_q < mk) begin
            a_buf[row_q][col_q] <= a_mem[cnt_q[AW-1:0]][DATA_W-1:0];
            if (4'(col_q) == dk_q - 4'd1) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else col_q <= col_q + 1'b1;
          end
          if (cnt_q < kn) begin
            w_buf[wk_q][wn_q] <= w_mem[cnt_q[AW-1:0]][DATA_W-1:0];
            if (4'(wn_q) == dn_q - 4'd1) begin
              wn_q <= '0;
              wk_q <= wk_q + 1'b1;
            end else wn_q <= wn_q + 1'b1;
          end
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == nload) state_q <= COMPUTE;
        end
        COMPUTE: begin
          t_q <= t_q + 5'd1;
          if (t_q == 5'(3*DIM-3)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (os_q)
            for (int r = 0; r < DIM; r++)
              for (int c = 0; c < DIM; c++) res[r][c] <= acc[r][c];
          cnt_q   <= '0;
          row_q   <= '0;
          col_q   <= '0;
          state_q <= WRITE;
        end
        WRITE: begin
          o_we_q    <= 1'b1;
          o_idx_q   <= cnt_q[AW-1:0];
          o_wdata_q <= res[row_q][col_q];
          if (4'(col_q) == dn_q - 4'd1) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else col_q <= col_q + 1'b1;
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == mn - 8'd1) state_q <= DONE;
        end
        DONE: if (!sp_start_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_mm_top.sv
// Bench for systolic_mm_top: table of matmul jobs checked against a reference
// model of O memory, plus hand-written control/abort/guard sequences.

module tb_systolic_mm_top;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sp_addr, sp_data_in, a_addr, a_data_in, w_addr, w_data_in, O_addr, O_data;
  logic [3:0]  sp_web, a_web, w_web;

  always #5 clk = ~clk;

  systolic_mm_top dut (
    .clk(clk), .reset(reset),
    .sp_addr(sp_addr), .sp_data_in(sp_data_in), .sp_web(sp_web),
    .a_addr(a_addr), .a_data_in(a_data_in), .a_web(a_web),
    .w_addr(w_addr), .w_data_in(w_data_in), .w_web(w_web),
    .O_addr(O_addr), .O_data(O_data)
  );

  typedef struct {
    int mode; int m; int k; int n; int ramp; int aval; int wval;
    int s0_idx; int s0_val; int s1_idx; int s1_val;
  } vec_t;
  typedef struct { int idx; logic [31:0] val; } exp_t;

  exp_t        sb[$];
  logic [31:0] model_o [64];
  bit          known [64];
  vec_t        vecs [10];
  int          checks = 0;
  int          errors = 0;

  task automatic sp_wr(input int idx, input int d);
    @(negedge clk);
    sp_addr = 32'h0000_0100 | 32'(idx * 4);
    sp_data_in = 32'(d);
    sp_web = 4'b0001;
    @(negedge clk);
    sp_web = 4'b0000;
  endtask

  task automatic mem_wr(input bit is_w, input int idx, input int val);
    @(negedge clk);
    if (is_w) begin
      w_addr = 32'h4000_0000 | 32'(idx * 4);
      w_data_in = {24'h5A5A5A, 8'(val)};
      w_web = 4'hF;
    end else begin
      a_addr = 32'h4000_0000 | 32'(idx * 4);
      a_data_in = {24'hA5A5A5, 8'(val)};
      a_web = 4'hF;
    end
    @(negedge clk);
    a_web = 4'h0;
    w_web = 4'h0;
  endtask

  function automatic int elem_a(vec_t v, int m, int k);
    return v.ramp != 0 ? m + k : v.aval;
  endfunction

  function automatic int elem_w(vec_t v, int k, int n);
    return v.ramp != 0 ? k - n : v.wval;
  endfunction

  task automatic load_job(input vec_t v);
    sp_wr(1, v.mode);
    sp_wr(2, v.m);
    sp_wr(3, v.k);
    sp_wr(4, v.n);
    for (int m = 0; m < v.m; m++)
      for (int k = 0; k < v.k; k++) mem_wr(1'b0, m * v.k + k, elem_a(v, m, k));
    for (int k = 0; k < v.k; k++)
      for (int n = 0; n < v.n; n++) mem_wr(1'b1, k * v.n + n, elem_w(v, k, n));
  endtask

  task automatic push_known();
    for (int i = 0; i < 64; i++)
      if (known[i]) sb.push_back('{i, model_o[i]});
  endtask

  // Reference: O[m][n] = sum_k A[m][k]*W[k][n]; invalid dims leave O untouched.
  task automatic expect_job(input vec_t v);
    int acc;
    if (v.m > 0 && v.m <= 8 && v.k > 0 && v.k <= 8 && v.n > 0 && v.n <= 8)
      for (int m = 0; m < v.m; m++)
        for (int n = 0; n < v.n; n++) begin
          acc = 0;
          for (int k = 0; k < v.k; k++) acc += elem_a(v, m, k) * elem_w(v, k, n);
          model_o[m * v.n + n] = 32'(acc);
          known[m * v.n + n] = 1'b1;
        end
    push_known();
  endtask

  task automatic check_word(input string tag, input int idx, input logic [31:0] want);
    @(negedge clk);
    O_addr = 32'h8000_0000 | 32'(idx * 4);
    #1;
    checks++;
    if (O_data !== want) begin
      errors++;
      $display("FAIL %s word %0d: got %0d (0x%08h) want %0d (0x%08h)",
               tag, idx, $signed(O_data), O_data, $signed(want), want);
    end
  endtask

  task automatic check_o(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_word(tag, e.idx, e.val);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    load_job(v);
    sp_wr(0, 1);
    expect_job(v);
    repeat (250) @(negedge clk);
    check_o(tag);
    check_word({tag, "_spot0"}, v.s0_idx, 32'(v.s0_val));
    check_word({tag, "_spot1"}, v.s1_idx, 32'(v.s1_val));
    sp_wr(0, 0);
  endtask

  initial begin
    vec_t ha, hb, hr, hk0, hn9, hp;
    reset = 1'b1;
    sp_addr = '0; sp_data_in = '0; sp_web = '0;
    a_addr = '0; a_data_in = '0; a_web = '0;
    w_addr = '0; w_data_in = '0; w_web = '0;
    O_addr = '0;
    for (int i = 0; i < 64; i++) begin
      known[i] = 1'b0;
      model_o[i] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    //           mode m  k  n  ramp aval  wval  s0  s0_val   s1  s1_val
    vecs[0] = '{1,   8, 8, 8, 0,   -2,   2,    0,  -32,     63, -32};
    vecs[1] = '{0,   8, 8, 8, 0,   -2,   2,    0,  -32,     63, -32};
    vecs[2] = '{0,   7, 8, 3, 0,   -2,   2,    0,  -32,     20, -32};
    vecs[3] = '{1,   7, 8, 3, 0,   -2,   2,    0,  -32,     20, -32};
    vecs[4] = '{0,   3, 4, 2, 1,   0,    0,    0,  14,      5,  12};
    vecs[5] = '{1,   3, 4, 2, 1,   0,    0,    0,  14,      5,  12};
    vecs[6] = '{0,   6, 7, 3, 0,   -128, -128, 0,  114688,  17, 114688};
    vecs[7] = '{1,   6, 7, 3, 0,   -128, -128, 0,  114688,  17, 114688};
    vecs[8] = '{0,   6, 7, 3, 0,   127,  -128, 0,  -113792, 17, -113792};
    vecs[9] = '{1,   6, 7, 3, 0,   127,  -128, 0,  -113792, 17, -113792};

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start held at 1 after DONE: new operands must not be picked up.
    ha = '{1, 4, 2, 5, 0, 1, 1, 0, 2, 19, 2};
    hb = '{0, 2, 3, 4, 0, 5, -3, 0, -45, 7, -45};
    load_job(ha);
    sp_wr(0, 1);
    expect_job(ha);
    repeat (250) @(negedge clk);
    check_o("held_first");
    load_job(hb);
    repeat (250) @(negedge clk);
    push_known();
    check_o("held_stable");
    sp_wr(0, 0);
    sp_wr(0, 1);
    expect_job(hb);
    repeat (250) @(negedge clk);
    check_o("restart");
    check_word("restart_spot", 7, -32'sd45);
    sp_wr(0, 0);

    // Reset during COMPUTE: no O writes, SP cleared, next job is clean.
    hr = '{1, 8, 8, 8, 0, 3, 1, 0, 24, 63, 24};
    load_job(hr);
    sp_wr(0, 1);
    repeat (72) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (250) @(negedge clk);
    push_known();
    check_o("reset_abort");
    hr.mode = 0;
    run_vec(hr, "after_reset");

    // Dimension guards leave O untouched.
    hk0 = '{1, 4, 0, 4, 0, 7, 7, 0, 0, 0, 0};
    hn9 = '{0, 2, 2, 9, 0, 7, 7, 0, 0, 0, 0};
    load_job(hk0);
    sp_wr(0, 1);
    expect_job(hk0);
    repeat (250) @(negedge clk);
    check_o("dim_k0");
    sp_wr(0, 0);
    load_job(hn9);
    sp_wr(0, 1);
    expect_job(hn9);
    repeat (250) @(negedge clk);
    check_o("dim_n9");
    sp_wr(0, 0);

    // Smallest legal job after the guards.
    hp = '{1, 1, 1, 1, 0, -1, -1, 0, 1, 1, 24};
    run_vec(hp, "dim_one");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
